// File: rtl/decoder_nx2n_seq_if.sv
// Handshake and line-select bundle for decoder_nx2n_seq.
// scan_dir exists only when DECODER_REVERSE_EN is defined.
interface decoder_nx2n_seq_if #(
  parameter int N = 4
);
  localparam int W = 1 << N;

  logic         en;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] addr;
  logic [W-1:0] D;
  logic         out_valid;
  logic         busy;
  logic         scan_done;
`ifdef DECODER_REVERSE_EN
  logic         scan_dir;

  modport master (
    output en, start, in_valid, addr, scan_dir,
    input  in_ready, D, out_valid, busy, scan_done
  );

  modport slave (
    input  en, start, in_valid, addr, scan_dir,
    output in_ready, D, out_valid, busy, scan_done
  );
`else
  modport master (
    output en, start, in_valid, addr,
    input  in_ready, D, out_valid, busy, scan_done
  );

  modport slave (
    input  en, start, in_valid, addr,
    output in_ready, D, out_valid, busy, scan_done
  );
`endif
endinterface

// File: rtl/decoder_nx2n_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready direct select and a line scan mode.
// Optional DECODER_REVERSE_EN adds scan_dir for downward scans.
//
// state | meaning
// IDLE  | direct accepts; start && en launches a scan
// SCAN  | each line held SCAN_DIV cycles; en low blanks D and freezes position
// DONE  | D inactive, scan_done pulse, back to IDLE
module decoder_nx2n_seq #(
  parameter int N          = 4,
  parameter int SCAN_DIV   = 1,
  parameter int ACTIVE_LOW = 0
) (
  input logic               clk,
  input logic               rst,
  decoder_nx2n_seq_if.slave bus
);
  localparam int           W        = 1 << N;
  localparam int           DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [N-1:0] IDX_LAST = N'(W - 1);
  localparam logic [W-1:0] D_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [N-1:0]     idx;
  logic [DIV_W-1:0] div;
  logic             paused;
  logic             rev;
  logic [W-1:0]     d_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             scan_done_q;

  logic             start_rev;
  logic [N-1:0]     first_idx;
  logic [N-1:0]     next_idx;
  logic             at_end;

`ifdef DECODER_REVERSE_EN
  assign start_rev = bus.scan_dir;
`else
  assign start_rev = 1'b0;
`endif

  assign first_idx = start_rev ? IDX_LAST : '0;
  assign next_idx  = rev ? (idx - 1'b1) : (idx + 1'b1);
  assign at_end    = rev ? (idx == '0) : (idx == IDX_LAST);

  function automatic logic [W-1:0] line_sel(input logic [N-1:0] i);
    return (W'(1) << i) ^ D_OFF;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      div         <= '0;
      paused      <= 1'b0;
      rev         <= 1'b0;
      d_q         <= D_OFF;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.en) begin
            d_q <= D_OFF;
          end else if (bus.start) begin
            state  <= SCAN;
            busy_q <= 1'b1;
            idx    <= first_idx;
            div    <= '0;
            paused <= 1'b0;
            rev    <= start_rev;
            d_q    <= line_sel(first_idx);
          end else if (bus.in_valid) begin
            d_q         <= line_sel(bus.addr);
            out_valid_q <= 1'b1;
          end
        end
        SCAN: begin
          if (!bus.en) begin
            d_q    <= D_OFF;
            div    <= '0;
            paused <= 1'b1;
          end else if (paused) begin
            // resume edge re-shows the frozen line; divider restarts from here
            paused <= 1'b0;
            d_q    <= line_sel(idx);
          end else if (div == DIV_LAST) begin
            div <= '0;
            if (at_end) begin
              state       <= DONE;
              busy_q      <= 1'b0;
              scan_done_q <= 1'b1;
              d_q         <= D_OFF;
            end else begin
              idx <= next_idx;
              d_q <= line_sel(next_idx);
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && bus.en && !bus.start;
  assign bus.D         = d_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.scan_done = scan_done_q;
endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// Bench for decoder_nx2n_seq: active-high and active-low instances share stimulus, SCAN_DIV=2.
module tb_decoder_nx2n_seq;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_nx2n_seq_if #(.N(N)) b0 ();
  decoder_nx2n_seq_if #(.N(N)) b1 ();

  decoder_nx2n_seq #(.N(N), .SCAN_DIV(SD), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  decoder_nx2n_seq #(.N(N), .SCAN_DIV(SD), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  assign b1.en       = b0.en;
  assign b1.start    = b0.start;
  assign b1.in_valid = b0.in_valid;
  assign b1.addr     = b0.addr;
`ifdef DECODER_REVERSE_EN
  assign b1.scan_dir = b0.scan_dir;
`endif

  typedef struct {
    logic         en;
    logic         start;
    logic         in_valid;
    logic [N-1:0] addr;
    logic         rdy;
    logic [W-1:0] d;
    logic         ov;
  } vec_t;

  vec_t vt[9];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input logic [W-1:0] exp);
    logic [W-1:0] inv;
    inv = ~exp;
    chk({nm, "_d"}, 32'(b0.D), 32'(exp));
    chk({nm, "_dn"}, 32'(b1.D), 32'(inv));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] oh(input int i);
    logic [W-1:0] one;
    one = 16'h0001;
    return one << i;
  endfunction

  // checks count lines from first, each for SD cycles; leaves time one edge past the last line
  task automatic run_lines(input string nm, input int first, input int step, input int count);
    int li;
    li = first;
    for (int j = 0; j < count; j++) begin
      for (int k = 0; k < SD; k++) begin
        chk_d(nm, oh(li));
        chk({nm, "_busy"}, 32'(b0.busy), 32'd1);
        chk({nm, "_sdone"}, 32'(b0.scan_done), 32'd0);
        chk({nm, "_ov"}, 32'(b0.out_valid), 32'd0);
        tick();
      end
      li += step;
    end
  endtask

  task automatic check_done(input string nm);
    chk_d({nm, "_end"}, 16'h0000);
    chk({nm, "_end_busy"}, 32'(b0.busy), 32'd0);
    chk({nm, "_end_sdone"}, 32'(b0.scan_done), 32'd1);
    chk({nm, "_end_sdone_n"}, 32'(b1.scan_done), 32'd1);
    tick();
    chk({nm, "_post_sdone"}, 32'(b0.scan_done), 32'd0);
    chk({nm, "_post_busy"}, 32'(b0.busy), 32'd0);
    chk({nm, "_post_rdy"}, 32'(b0.in_ready), 32'd1);
    chk_d({nm, "_post"}, 16'h0000);
  endtask

  task automatic launch(input string nm);
    b0.start    = 1'b1;
    b0.in_valid = 1'b0;
    #1;
    chk({nm, "_start_rdy"}, 32'(b0.in_ready), 32'd0);
    tick();
    b0.start = 1'b0;
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b1, 4'hE, 1'b1, 16'h4000, 1'b1};
    vt[1] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 16'h4000, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 16'h0001, 1'b1};
    vt[3] = '{1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 16'h0000, 1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b0, 4'h5, 1'b1, 16'h0000, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b1, 4'h3, 1'b1, 16'h0008, 1'b1};
    vt[6] = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 16'h8000, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 16'h0000, 1'b0};
    vt[8] = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b1, 16'h0080, 1'b1};

    // reset with start held high
    rst         = 1'b1;
    b0.en       = 1'b1;
    b0.start    = 1'b1;
    b0.in_valid = 1'b0;
    b0.addr     = '0;
`ifdef DECODER_REVERSE_EN
    b0.scan_dir = 1'b0;
`endif
    repeat (3) tick();
    chk_d("reset", 16'h0000);
    chk("reset_ov", 32'(b0.out_valid), 32'd0);
    chk("reset_busy", 32'(b0.busy), 32'd0);
    chk("reset_busy_n", 32'(b1.busy), 32'd0);
    chk("reset_sdone", 32'(b0.scan_done), 32'd0);
    rst      = 1'b0;
    b0.start = 1'b0;
    #1;
    chk("reset_rdy", 32'(b0.in_ready), 32'd1);

    // direct accepts and enable gating
    for (int i = 0; i < 9; i++) begin
      b0.en       = vt[i].en;
      b0.start    = vt[i].start;
      b0.in_valid = vt[i].in_valid;
      b0.addr     = vt[i].addr;
      #1;
      chk($sformatf("vec%0d_rdy", i), 32'(b0.in_ready), 32'(vt[i].rdy));
      tick();
      chk_d($sformatf("vec%0d", i), vt[i].d);
      chk($sformatf("vec%0d_ov", i), 32'(b0.out_valid), 32'(vt[i].ov));
      chk($sformatf("vec%0d_ov_n", i), 32'(b1.out_valid), 32'(vt[i].ov));
      chk($sformatf("vec%0d_busy", i), 32'(b0.busy), 32'd0);
    end
    b0.en       = 1'b1;
    b0.start    = 1'b0;
    b0.in_valid = 1'b0;
    tick();
    chk("hold_ov", 32'(b0.out_valid), 32'd0);
    chk_d("hold", 16'h0080);

    // start wins over in_valid; a second start mid-scan is ignored
    b0.start    = 1'b1;
    b0.in_valid = 1'b1;
    b0.addr     = 4'h5;
    #1;
    chk("prio_rdy", 32'(b0.in_ready), 32'd0);
    tick();
    b0.start    = 1'b0;
    b0.in_valid = 1'b0;
    run_lines("scanA", 0, 1, 5);
    b0.start    = 1'b1;
    b0.in_valid = 1'b1;
    #1;
    chk("scanA_mid_rdy", 32'(b0.in_ready), 32'd0);
    run_lines("scanA", 5, 1, 1);
    b0.start    = 1'b0;
    b0.in_valid = 1'b0;
    run_lines("scanA", 6, 1, 10);
    check_done("scanA");

    // pause at line 7 for 5 cycles
    launch("scanB");
    run_lines("scanB", 0, 1, 7);
    chk_d("scanB_at7", 16'h0080);
    b0.en = 1'b0;
    #1;
    chk("scanB_pause_rdy", 32'(b0.in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_d($sformatf("scanB_pause%0d", i), 16'h0000);
      chk($sformatf("scanB_pause%0d_busy", i), 32'(b0.busy), 32'd1);
      chk($sformatf("scanB_pause%0d_ov", i), 32'(b0.out_valid), 32'd0);
    end
    b0.en = 1'b1;
    tick();
    run_lines("scanB", 7, 1, 9);
    check_done("scanB");

    // reset while line 9 is showing
    launch("scanC");
    run_lines("scanC", 0, 1, 9);
    chk_d("scanC_at9", 16'h0200);
    rst = 1'b1;
    tick();
    chk_d("scanC_rst", 16'h0000);
    chk("scanC_rst_busy", 32'(b0.busy), 32'd0);
    chk("scanC_rst_sdone", 32'(b0.scan_done), 32'd0);
    chk("scanC_rst_ov", 32'(b0.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("scanC_rdy", 32'(b0.in_ready), 32'd1);
    tick();
    chk_d("scanC_idle", 16'h0000);
    chk("scanC_idle_busy", 32'(b0.busy), 32'd0);

`ifdef DECODER_REVERSE_EN
    b0.scan_dir = 1'b1;
    launch("scanR");
    b0.scan_dir = 1'b0;
    run_lines("scanR", 15, -1, 16);
    check_done("scanR");
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/decoder_nx2n_seq.md
Name: decoder_nx2n_seq

Overview:
- Parametrised, registered N-to-2^N one-hot decoder.
- Generalises the fixed 4x16 combinational decoder in three ways: width parameter, a valid/ready input handshake, and an autonomous scan mode that sweeps every output line in turn.
- Drives row/segment/chip-select lines in downstream display and memory-select blocks.

Parameters:
- N, 4: address width; output width is 2^N (N >= 1).
- SCAN_DIV, 1: clock cycles each line stays active in scan mode (>= 1).
- ACTIVE_LOW, 0: 1 inverts all D bits (selected line low, others high).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable.
- start  input  1  single-cycle request to begin a scan.
- in_valid  input  1  addr is valid.
- in_ready  output  1  block accepts addr this cycle.
- addr  input  N  binary line select.
- D  output  2^N  registered one-hot outputs; polarity per ACTIVE_LOW.
- out_valid  output  1  one-cycle pulse when D updates from a direct accept.
- busy  output  1  high while a scan is in progress.
- scan_done  output  1  one-cycle pulse at scan completion.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled on the rising clk edge.
- Reset values:
  - D inactive: all 0, or all 1 if ACTIVE_LOW.
  - out_valid = 0, busy = 0, scan_done = 0.
  - State IDLE; scan index 0; divider count 0.
- A reset in any state, including mid-scan, returns all of the above on the next edge. A start held high through reset is ignored until after reset deasserts.
- States: IDLE, SCAN, DONE.
- in_ready is combinational: in_ready = (state == IDLE) && en && !start.
- IDLE, direct accept (in_valid && in_ready):
  - Next edge: D = one-hot(addr), out_valid = 1 for exactly one cycle.
  - D holds that value until the next accept, a scan start, en low, or reset.
  - Latency from accept to D is 1 cycle.
- IDLE, start && en:
  - Next edge: enter SCAN, busy = 1, D = one-hot(0), index = 0, divider = 0.
  - start wins over a simultaneous in_valid; no accept occurs that cycle.
  - start when en = 0 is ignored.
- SCAN:
  - Divider counts 0..SCAN_DIV-1 and holds the current line for SCAN_DIV cycles.
  - When the divider wraps, index increments and D moves to the next line.
  - After index 2^N-1 has been held SCAN_DIV cycles, go to DONE.
  - start and in_valid are ignored (in_ready = 0).
  - Total scan length is exactly 2^N * SCAN_DIV cycles with busy = 1.
- DONE:
  - D inactive, busy = 0, scan_done = 1 for one cycle.
  - Next edge: IDLE.
  - The final D value before DONE is the line 2^N-1; the line 0 is not repeated.
- en low:
  - D is forced inactive on the next edge.
  - Scan index and divider freeze; busy stays asserted.
  - in_ready = 0; out_valid is not asserted.
  - When en returns high, the scan resumes at the same index with a fresh divider count. In IDLE, D stays inactive until the next accept.
- Width rules:
  - addr is always in range; D index = addr.
  - The index counter is N bits. The wrap from 2^N-1 is never used as a value because the scan terminates first.

Optional Feature:
- Macro: DECODER_REVERSE_EN.
- Defined:
  - Adds port scan_dir (input, 1 bit), sampled only with an accepted start.
  - scan_dir = 1 scans from 2^N-1 down to 0; scan_dir = 0 scans up.
  - The scan ends after line 0 (reverse) or after line 2^N-1 (forward).
- Not defined:
  - Port scan_dir is absent.
  - Scans are upward only; behaviour otherwise identical.

Test Plan:
- Reset/direct: N=4, ACTIVE_LOW=0. After rst, apply addr=4'b1110 with in_valid=1 → next cycle D=16'h4000 and out_valid pulses once. Then addr=0 → D=16'h0001.
- Polarity: ACTIVE_LOW=1, accept addr=4'd3 → D=16'hFFF7. During reset → D=16'hFFFF.
- Scan: SCAN_DIV=2, pulse start → busy for 32 cycles; D steps 0001, 0002, …, 8000, each line held 2 cycles; then scan_done pulses once and D=0.
- Priority/ignore: start and in_valid together in IDLE → scan begins, in_ready=0, no out_valid. A second start mid-scan → total scan length is still 32 cycles.
- Pause: drop en for 5 cycles at index 7 → D=0 while en is low and busy stays 1. On resume, D=16'h0080 for a full SCAN_DIV cycles, and the scan completes normally.
- Reset mid-scan: assert rst at index 9 → next cycle D=0, busy=0, scan_done=0; in_ready=1 the cycle after, with en=1 and start=0. With DECODER_REVERSE_EN and scan_dir=1, a scan runs 8000 down to 0001.
